// File: rtl/local_pattern_table_pkg.sv
// local_pattern_table_pkg: shared branch-predictor types, counter encodings and saturating update.
package local_pattern_table_pkg;
  localparam int LPT_HIST_W = 4;
  localparam int LPT_CTR_W = 2;
  localparam logic [1:0] STRONG_NT = 2'd0;
  localparam logic [1:0] WEAK_NT = 2'd1;
  localparam logic [1:0] WEAK_T = 2'd2;
  localparam logic [1:0] STRONG_T = 2'd3;
  typedef struct packed {
    logic [LPT_HIST_W-1:0] hist;
    logic taken;
  } lpt_upd_t;
  function automatic int unsigned sat_ctr(input int unsigned ctr, input logic taken, input int unsigned max);
    return taken ? (ctr == max ? ctr : ctr + 1) : (ctr == 0 ? ctr : ctr - 1);
  endfunction
endpackage

// File: rtl/local_pattern_table_fifo.sv
// bp_update_fifo: generic synchronous FIFO with clear; pointers carry an extra wrap bit.
module bp_update_fifo #(
  parameter int DATA_W = 5,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic do_push, do_pop;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full && !clear;
  assign do_pop = pop && !empty && !clear;
  assign dout = mem[rptr[AW-1:0]];
  always_ff @(posedge clk)
    if (do_push) mem[wptr[AW-1:0]] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
endmodule

// File: rtl/local_pattern_table.sv
// local_pattern_table: history-indexed saturating counters, combinational predict, FIFO-queued updates.
module local_pattern_table
  import local_pattern_table_pkg::*;
#(
  parameter int HIST_W = LPT_HIST_W,
  parameter int CTR_W = LPT_CTR_W,
  parameter int FIFO_DEPTH = 4,
  parameter logic [CTR_W-1:0] CTR_INIT = CTR_W'(WEAK_NT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [HIST_W-1:0] rd_hist,
  output logic              pred_taken,
  output logic [CTR_W-1:0]  pred_ctr,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [HIST_W-1:0] upd_hist,
  input  logic              upd_taken,
  output logic              busy
);
  localparam int DEPTH = 1 << HIST_W;
  localparam int CTR_MAX = (1 << CTR_W) - 1;
  logic [CTR_W-1:0] tbl [DEPTH];
  logic [HIST_W:0] head;
  logic full, empty;
  assign upd_ready = !full;
  assign busy = !empty;
  assign pred_ctr = tbl[rd_hist];
  assign pred_taken = pred_ctr[CTR_W-1];
  bp_update_fifo #(.DATA_W(HIST_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .push(upd_valid),
    .pop(1'b1),
    .din({upd_hist, upd_taken}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  // head is {hist, taken}; the pop and the counter write share one edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= CTR_INIT;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= CTR_INIT;
    end else if (!empty) begin
      tbl[head[HIST_W:1]] <= CTR_W'(sat_ctr(32'(tbl[head[HIST_W:1]]), head[0], CTR_MAX));
    end
endmodule
